// File: rtl/cipher_pkg.sv
// cipher_pkg: constants and state encoding shared by the key assembler and the stream cipher
package cipher_pkg;
   localparam int KEY_WIDTH  = 512;
   localparam int DATA_WIDTH = 8;
   localparam int KEY_WORDS  = KEY_WIDTH / DATA_WIDTH;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;
endpackage

// File: rtl/xor_key_selector.sv
// xor_key_selector: picks key word [iIdx] out of the flat key register
module xor_key_selector #(
   parameter int KEY_WIDTH  = 512,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = 6
) (
   input  logic [KEY_WIDTH-1:0]  iKey,
   input  logic [IDX_W-1:0]      iIdx,
   output logic [DATA_WIDTH-1:0] oByte
);
   assign oByte = iKey[DATA_WIDTH*int'(iIdx) +: DATA_WIDTH];
endmodule

// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: XORs a byte stream with a snapshotted key, rotating through its words
module xor_stream_cipher #(
   parameter int KEY_WIDTH    = cipher_pkg::KEY_WIDTH,
   parameter int DATA_WIDTH   = cipher_pkg::DATA_WIDTH,
   localparam int KEY_WORDS   = KEY_WIDTH / DATA_WIDTH,
   localparam int IDX_W       = $clog2(KEY_WORDS)
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [KEY_WIDTH-1:0]  iAssembled_key,
   input  logic                  iCan_encrypt,
   input  logic                  iRestart,
   input  logic [DATA_WIDTH-1:0] iData,
   input  logic                  iData_valid,
   output logic                  oData_ready,
   output logic [DATA_WIDTH-1:0] oOut_data,
   output logic                  oOut_valid,
   input  logic                  iOut_ready,
   output logic [IDX_W-1:0]      oKey_idx,
   output logic                  oKey_wrap,
   output logic                  oBusy
);
   import cipher_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

   stateT state, nextState;
   logic [KEY_WIDTH-1:0] keyReg;
   logic [DATA_WIDTH-1:0] keyByte;
   logic accept;

   xor_key_selector #(
      .KEY_WIDTH(KEY_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_W(IDX_W)
   ) uSel (
      .iKey(keyReg),
      .iIdx(oKey_idx),
      .oByte(keyByte)
   );

   assign oBusy = state == RUN;
   assign oData_ready = oBusy && (!oOut_valid || iOut_ready);
   assign accept = iData_valid && oData_ready;

   // state register
   always_ff @(posedge iClk or negedge iRst)
      if (!iRst) state <= IDLE;
      else state <= nextState;

   // RUN lasts exactly as long as the assembler reports a complete key
   always_comb begin
      nextState = IDLE;
      nextState = iCan_encrypt ? RUN : IDLE;
   end

   // key is frozen for the whole RUN period; only the IDLE->RUN edge reloads it
   always_ff @(posedge iClk or negedge iRst)
      if (!iRst) keyReg <= '0;
      else if (state == IDLE && iCan_encrypt) keyReg <= iAssembled_key;

   // key index: restart and leaving RUN override the post-accept increment
   always_ff @(posedge iClk or negedge iRst)
      if (!iRst) begin
         oKey_idx  <= '0;
         oKey_wrap <= 1'b0;
      end else begin
         oKey_wrap <= accept && oKey_idx == LAST_IDX && !iRestart;
         if (state == IDLE || !iCan_encrypt || iRestart) oKey_idx <= '0;
         else if (accept) oKey_idx <= oKey_idx == LAST_IDX ? '0 : oKey_idx + 1'b1;
      end

   // output register: load on accept, clear valid on a drain with nothing new behind it
   always_ff @(posedge iClk or negedge iRst)
      if (!iRst) begin
         oOut_data  <= '0;
         oOut_valid <= 1'b0;
      end else if (accept) begin
         oOut_data  <= iData ^ keyByte;
         oOut_valid <= 1'b1;
      end else if (iOut_ready) oOut_valid <= 1'b0;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb_xor_stream_cipher: directed plus randomized checks against a queue-based reference model
module tb_xor_stream_cipher;
   logic iClk = 1'b0, iRst = 1'b0, iCan_encrypt = 1'b0, iRestart = 1'b0;
   logic iData_valid = 1'b0, iOut_ready = 1'b0;
   logic [511:0] iAssembled_key = '0;
   logic [7:0] iData = '0;
   logic oData_ready, oOut_valid, oKey_wrap, oBusy;
   logic [7:0] oOut_data;
   logic [5:0] oKey_idx;

   int checks = 0, failures = 0, idx = 0, wraps = 0;
   logic [511:0] keyModel = '0;
   logic [7:0] qOut[$];
   logic run = 1'b0, expWrap = 1'b0;

   xor_stream_cipher dut (
      .iClk(iClk), .iRst(iRst), .iAssembled_key(iAssembled_key), .iCan_encrypt(iCan_encrypt),
      .iRestart(iRestart), .iData(iData), .iData_valid(iData_valid), .oData_ready(oData_ready),
      .oOut_data(oOut_data), .oOut_valid(oOut_valid), .iOut_ready(iOut_ready),
      .oKey_idx(oKey_idx), .oKey_wrap(oKey_wrap), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randKey();
      for (int i = 0; i < 16; i++) iAssembled_key[32*i +: 32] = $urandom;
   endtask

   // called at posedge+1 with inputs driven; checks, advances the model, returns at next posedge+1
   task automatic cycle();
      logic expValid, expReady, acc;
      #1;
      expValid = qOut.size() != 0;
      expReady = run && (!expValid || iOut_ready);
      chk("valid", oOut_valid, expValid);
      if (expValid) chk("data", oOut_data, qOut[0]);
      chk("ready", oData_ready, expReady);
      chk("busy", oBusy, run);
      chk("idx", oKey_idx, idx);
      chk("wrap", oKey_wrap, expWrap);
      acc = iData_valid && expReady;
      if (expValid && iOut_ready) void'(qOut.pop_front());
      expWrap = 1'b0;
      if (acc) begin
         qOut.push_back(iData ^ keyModel[8*idx +: 8]);
         expWrap = idx == 63 && !iRestart;
         idx = (idx + 1) % 64;
      end
      if (run && (iRestart || !iCan_encrypt)) idx = 0;
      if (!run && iCan_encrypt) keyModel = iAssembled_key;
      run = iCan_encrypt;
      @(posedge iClk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      iData = d;
      iData_valid = 1'b1;
      cycle();
      iData_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge iClk);
      #1;
      chk("rst_data", oOut_data, 0);
      chk("rst_valid", oOut_valid, 0);
      chk("rst_idx", oKey_idx, 0);
      chk("rst_wrap", oKey_wrap, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_ready", oData_ready, 0);
      iRst = 1'b1;
      for (int i = 0; i < 64; i++) iAssembled_key[8*i +: 8] = 8'(i);
      iCan_encrypt = 1'b1;
      iOut_ready = 1'b1;
      cycle();
      chk("up_busy", oBusy, 1);
      chk("up_ready", oData_ready, 1);
      send(8'hFF);
      chk("idx0", oOut_data, 8'hFF);
      repeat (4) send(8'h00);
      send(8'hFF);
      chk("idx5", oOut_data, 8'hFA);
      iRestart = 1'b1;
      cycle();
      iRestart = 1'b0;
      chk("restart_idx", oKey_idx, 0);
      for (int i = 0; i < 65; i++) begin
         send(8'h00);
         chk("wrap_data", oOut_data, i % 64);
         chk("wrap_pulse", oKey_wrap, i == 63);
         wraps += int'(oKey_wrap);
      end
      chk("wrap_count", wraps, 1);
      chk("wrap_idx", oKey_idx, 1);
      iRestart = 1'b1;
      cycle();
      iRestart = 1'b0;
      iOut_ready = 1'b0;
      send(8'hAA);
      chk("bp_first", oOut_data, 8'hAA);
      iData = 8'h55;
      iData_valid = 1'b1;
      repeat (2) begin
         cycle();
         chk("bp_hold", oOut_data, 8'hAA);
         chk("bp_ready", oData_ready, 0);
      end
      iOut_ready = 1'b1;
      cycle();
      chk("bp_second", oOut_data, 8'h54);
      chk("bp_idx", oKey_idx, 2);
      iData_valid = 1'b0;
      cycle();
      chk("bp_drained", oOut_valid, 0);
      repeat (8) send(8'($urandom));
      iRestart = 1'b1;
      send(8'h00);
      iRestart = 1'b0;
      chk("rc_data", oOut_data, 8'h0A);
      chk("rc_idx", oKey_idx, 0);
      chk("rc_wrap", oKey_wrap, 0);
      randKey();
      iAssembled_key[7:0] = 8'hC3;
      send(8'h00);
      chk("old_key", oOut_data, 8'h00);
      iCan_encrypt = 1'b0;
      cycle();
      chk("idle_idx", oKey_idx, 0);
      chk("idle_busy", oBusy, 0);
      iCan_encrypt = 1'b1;
      cycle();
      send(8'h00);
      chk("new_key", oOut_data, 8'hC3);
      for (int n = 0; n < 400; n++) begin
         iData = 8'($urandom);
         iData_valid = $urandom_range(0, 3) != 0;
         iOut_ready = $urandom_range(0, 2) != 0;
         iRestart = $urandom_range(0, 19) == 0;
         iCan_encrypt = $urandom_range(0, 29) != 0;
         if ($urandom_range(0, 9) == 0) randKey();
         cycle();
      end
      iData_valid = 1'b0;
      iRestart = 1'b0;
      iCan_encrypt = 1'b1;
      iOut_ready = 1'b1;
      repeat (2) cycle();
      iRestart = 1'b1;
      cycle();
      iRestart = 1'b0;
      repeat (37) send(8'($urandom));
      chk("pre_idx", oKey_idx, 37);
      chk("pre_valid", oOut_valid, 1);
      iRst = 1'b0;
      #1;
      chk("ar_data", oOut_data, 0);
      chk("ar_valid", oOut_valid, 0);
      chk("ar_idx", oKey_idx, 0);
      chk("ar_wrap", oKey_wrap, 0);
      chk("ar_busy", oBusy, 0);
      chk("ar_ready", oData_ready, 0);
      qOut.delete();
      idx = 0;
      run = 1'b0;
      expWrap = 1'b0;
      iCan_encrypt = 1'b0;
      @(posedge iClk);
      #1;
      iRst = 1'b1;
      cycle();
      chk("post_ready", oData_ready, 0);
      chk("post_busy", oBusy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
